data_cache: RTL
===============

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter LINES, default 16: number of direct-mapped lines, one 32-bit word per line; power of two.
REQ-002 Parameter MMIO_BASE, default 32'hFFFF_F000: addresses at or above this value are uncached MMIO.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cpu_rd  input  1  MEM-stage load request.
REQ-006 cpu_wr  input  1  MEM-stage store request.
REQ-007 cpu_addr  input  32  byte address; bits [1:0] ignored (word access).
REQ-008 cpu_wdata  input  32  store data.
REQ-009 cpu_rdata  output  32  load data.
REQ-010 cpu_stall  output  1  high = CPU holds the pipeline and keeps its request stable.
REQ-011 mem_req  output  1  backing-memory request valid.
REQ-012 mem_we  output  1  backing-memory write enable, qualified by mem_req.
REQ-013 mem_addr  output  32  backing-memory word address (cpu_addr with [1:0]=0).
REQ-014 mem_wdata  output  32  backing-memory write data.
REQ-015 mem_rdata  input  32  backing-memory read data, valid when mem_ack=1.
REQ-016 mem_ack  input  1  one-cycle completion pulse from backing memory; arbitrary latency of 1 cycle or more.

Function
REQ-017 Address split: index = addr[2+IDX-1:2] with IDX=log2(LINES); tag = addr[31:2+IDX].
REQ-018 States: IDLE, READ_MISS, WRITE_THRU, UNCACHED_RD, DONE.
REQ-019 IDLE, cpu_rd, cacheable, valid+tag match (hit): cpu_rdata = line data combinationally; cpu_stall=0; stay IDLE.
REQ-020 IDLE, cpu_rd, cacheable, miss: cpu_stall=1 combinationally in the same cycle; go to READ_MISS.
REQ-021 IDLE, cpu_rd, address >= MMIO_BASE: cpu_stall=1; go to UNCACHED_RD; the cache is never read or allocated.
REQ-022 IDLE, cpu_wr (any address): cpu_stall=1; go to WRITE_THRU. Writes are write-through and no-write-allocate.
REQ-023 cpu_rd and cpu_wr both high is handled as a write; cpu_rd is ignored.
REQ-024 READ_MISS, UNCACHED_RD, WRITE_THRU: mem_req=1, cpu_stall=1, with mem_addr, mem_we and mem_wdata driven from the held CPU request.
REQ-025 mem_req stays high until the cycle mem_ack=1; mem_ack received while mem_req=0 is ignored.
REQ-026 On mem_ack in READ_MISS: write mem_rdata into the line, set valid, set the tag, capture the data into a return buffer, go to DONE.
REQ-027 On mem_ack in UNCACHED_RD: capture mem_rdata into the return buffer only, go to DONE.
REQ-028 On mem_ack in WRITE_THRU: if the address is cacheable and hits, update the line data with cpu_wdata; go to DONE.
REQ-029 DONE: cpu_stall=0, mem_req=0, cpu_rdata = return buffer; go to IDLE unconditionally. The request is consumed exactly once.
REQ-030 In IDLE with no request, and in every state except DONE and a read hit, cpu_rdata = 0.
REQ-031 mem_req is deasserted in the cycle after mem_ack; there are no back-to-back requests without passing through DONE.

Reset
REQ-032 rst=1 at a clock edge: state goes to IDLE, all valid bits clear in that single cycle, and the return buffer clears.
REQ-033 Reset values: cpu_stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0.
REQ-034 Reset during READ_MISS, UNCACHED_RD or WRITE_THRU aborts the transaction. No line is updated, and a later mem_ack is ignored.
REQ-035 Tag and data arrays are not reset; only the valid bits are.

Structure
REQ-036 State encoding, MMIO_BASE default and address-field widths live in the shared constants header.
REQ-037 One sub-module, dcache_array, holds the tag, valid and data storage: asynchronous read, synchronous write, synchronous valid clear.
REQ-038 Outputs are driven from the registered state and the held request; there are no combinational paths from mem_* to cpu_stall other than through the state register.

Verification
REQ-039 After reset, rd 0x0000_0040 with memory returning 0xDEAD_BEEF after 3 cycles -> stall held 4 cycles, DONE returns 0xDEAD_BEEF; a repeat read hits with stall=0.
REQ-040 wr 0x0000_0040 data 0x1234_5678 after the line is cached -> one mem write with mem_we=1; a following rd hits and returns 0x1234_5678 with no mem_req.
REQ-041 rd 0x0000_0040 and then rd 0x0000_0080 (same index, LINES=16) -> the second read misses and evicts; a third rd of 0x40 misses again.
REQ-042 rd 0xFFFF_F004 twice, memory returning 0x0000_00AA and then 0x0000_00BB -> both go to memory, both values are returned, no allocation.
REQ-043 rst pulsed in READ_MISS before mem_ack, with ack then arriving -> mem_req=0 after reset, and a subsequent rd of the same address misses.
REQ-044 cpu_rd=cpu_wr=1 to 0x0000_0010 -> write-through only, mem_we=1, cpu_rdata=0 in DONE.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared constants for the direct-mapped write-through data cache:
// controller states, default geometry and address-field helpers.
package data_cache_pkg;

   localparam int          ADDR_W            = 32;
   localparam int          OFFSET_W          = 2;
   localparam int          DEFAULT_LINES     = 16;
   localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_F000;

   typedef enum logic [2:0] {
      IDLE,
      READ_MISS,
      WRITE_THRU,
      UNCACHED_RD,
      DONE
   } state_t;

   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for the cache: asynchronous read, synchronous write.
// Only the valid bits are reset; every write also marks its line valid.
module dcache_array
   import data_cache_pkg::*;
#(
   parameter int LINES = DEFAULT_LINES,
   parameter int IDX_W = $clog2(LINES),
   parameter int TAG_W = ADDR_W - OFFSET_W - IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_index,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [31:0]      rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_index,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [31:0]      wr_data
);

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];
   logic [31:0]      data [LINES];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= 1'b1;
      end
   end

   // Tag and data are deliberately left unreset; valid alone qualifies them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_index] <= wr_tag;
         data[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_data  = data[rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with an uncached
// MMIO window and a single outstanding backing-memory transaction.
module data_cache
   import data_cache_pkg::*;
#(
   parameter int          LINES     = DEFAULT_LINES,
   parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

   state_t      state, next_state;
   logic [31:0] req_addr, req_wdata, ret_buf;
   logic [31:0] look_addr;
   logic        look_cacheable, hit, in_mem_state;
   logic        arr_valid, arr_wr_en;
   logic [TAG_W-1:0] arr_tag;
   logic [31:0] arr_data, arr_wr_data;

   // Lookups use the live CPU address in IDLE and the captured request otherwise.
   assign look_addr      = (state == IDLE) ? cpu_addr : req_addr;
   assign look_cacheable = look_addr < MMIO_BASE;
   assign hit            = arr_valid && (arr_tag == look_addr[ADDR_W-1:OFFSET_W+IDX_W]);
   assign in_mem_state   = (state == READ_MISS) || (state == WRITE_THRU) || (state == UNCACHED_RD);

   assign arr_wr_en   = !rst && mem_ack &&
                        ((state == READ_MISS) || ((state == WRITE_THRU) && look_cacheable && hit));
   assign arr_wr_data = (state == READ_MISS) ? mem_rdata : req_wdata;

   dcache_array #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_index (look_addr[OFFSET_W+:IDX_W]),
      .rd_valid (arr_valid),
      .rd_tag   (arr_tag),
      .rd_data  (arr_data),
      .wr_en    (arr_wr_en),
      .wr_index (req_addr[OFFSET_W+:IDX_W]),
      .wr_tag   (req_addr[ADDR_W-1:OFFSET_W+IDX_W]),
      .wr_data  (arr_wr_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A simultaneous read and write is treated as a write.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (cpu_wr) begin
               next_state = WRITE_THRU;
            end else if (cpu_rd) begin
               if (!look_cacheable) begin
                  next_state = UNCACHED_RD;
               end else if (!hit) begin
                  next_state = READ_MISS;
               end
            end
         end
         READ_MISS, WRITE_THRU, UNCACHED_RD: begin
            if (mem_ack) begin
               next_state = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_addr  <= '0;
         req_wdata <= '0;
         ret_buf   <= '0;
      end else begin
         if (state == IDLE && next_state != IDLE) begin
            req_addr  <= word_addr(cpu_addr);
            req_wdata <= cpu_wdata;
         end
         if (mem_ack && (state == READ_MISS || state == UNCACHED_RD)) begin
            ret_buf <= mem_rdata;
         end else if (mem_ack && state == WRITE_THRU) begin
            ret_buf <= '0;
         end
      end
   end

   always_comb begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if (cpu_wr || (cpu_rd && (!look_cacheable || !hit))) begin
               cpu_stall = 1'b1;
            end else if (cpu_rd) begin
               cpu_rdata = arr_data;
            end
         end
         DONE: cpu_rdata = ret_buf;
         default: begin
            if (in_mem_state) begin
               cpu_stall = 1'b1;
               mem_req   = 1'b1;
               mem_addr  = req_addr;
               mem_we    = (state == WRITE_THRU);
               mem_wdata = (state == WRITE_THRU) ? req_wdata : '0;
            end
         end
      endcase
   end

endmodule
